// File: rtl/npu_sa_pkg.sv
// npu_sa_pkg: shared state type and sizing helpers for the systolic-array tile sequencer.
package npu_sa_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FEED,
    FLUSH,
    DRAIN,
    DONE
  } sa_state_e;

  localparam int ACC_MULT  = 3;
  localparam int ACC_WIDTH = ACC_MULT * 8;

  // Cycles for the last operand to cross an N x N array after it enters lane 0.
  function automatic int flush_cycles(input int n);
    return 2 * n - 1;
  endfunction

endpackage

// File: rtl/sa_skew_line.sv
// sa_skew_line: depth-D operand delay line for one array lane, with a valid bit so
// that lanes without live data present zero to the array.
module sa_skew_line #(
  parameter int D = 1,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic [W-1:0] out_data
);

  // in_valid is the SRAM read strobe; its data arrives one cycle later, hence D+1 valid stages.
  logic [D:0] vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= in_valid;
      for (int i = 1; i <= D; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  if (D == 0) begin : g_direct
    assign out_data = vld_q[0] ? in_data : '0;
  end else begin : g_delay
    logic [W-1:0] dat_q [D];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < D; i++) dat_q[i] <= '0;
      end else begin
        dat_q[0] <= in_data;
        for (int i = 1; i < D; i++) dat_q[i] <= dat_q[i-1];
      end
    end

    assign out_data = vld_q[D] ? dat_q[D-1] : '0;
  end

endmodule

// File: rtl/sa_tile_sequencer.sv
// sa_tile_sequencer: runs one output-stationary tile (operand fetch, skew, flush, drain).
// Build option SA_SEQ_PERF_EN adds the perf_cycles / perf_stall counters.
//   state | meaning
//   IDLE  | waiting for a tile command
//   FEED  | reading k operand vectors; first cycle clears the accumulators
//   FLUSH | wavefront still travelling through the array
//   DRAIN | handing result rows to the PPU
//   DONE  | tile finished; done pulses on the following cycle
module sa_tile_sequencer
  import npu_sa_pkg::*;
#(
  parameter int ARRAY_SIZE = 4,
  parameter int DATA_WIDTH = 8,
  parameter int K_WIDTH    = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    start_valid,
  output logic                                    start_ready,
  input  logic [K_WIDTH-1:0]                      cmd_k,
  input  logic [ADDR_WIDTH-1:0]                   cmd_a_base,
  input  logic [ADDR_WIDTH-1:0]                   cmd_b_base,
  output logic                                    a_rd_en,
  output logic [ADDR_WIDTH-1:0]                   a_rd_addr,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0]        a_rd_data,
  output logic                                    b_rd_en,
  output logic [ADDR_WIDTH-1:0]                   b_rd_addr,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0]        b_rd_data,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0]        row_in,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0]        col_in,
  output logic                                    pe_clear,
  output logic                                    pe_en,
  output logic [$clog2(ARRAY_SIZE)-1:0]           row_sel,
  input  logic [ARRAY_SIZE*ACC_MULT*DATA_WIDTH-1:0] array_out,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [ARRAY_SIZE*ACC_MULT*DATA_WIDTH-1:0] out_data,
`ifdef SA_SEQ_PERF_EN
  output logic [31:0]                             perf_cycles,
  output logic [31:0]                             perf_stall,
`endif
  output logic                                    busy,
  output logic                                    done
);

  localparam int SEL_W = $clog2(ARRAY_SIZE);
  localparam int TMR_W = $clog2(flush_cycles(ARRAY_SIZE) + 1);
  localparam logic [SEL_W-1:0] LAST_ROW   = SEL_W'(ARRAY_SIZE - 1);
  localparam logic [TMR_W-1:0] FLUSH_LOAD = TMR_W'(flush_cycles(ARRAY_SIZE));

  sa_state_e             state_q, state_d;
  logic [K_WIDTH-1:0]    feed_left_q;
  logic [ADDR_WIDTH-1:0] a_addr_q, b_addr_q;
  logic [TMR_W-1:0]      tmr_q;
  logic [SEL_W-1:0]      row_q;
  logic                  pe_clear_q;
  logic                  done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      feed_left_q <= '0;
      a_addr_q    <= '0;
      b_addr_q    <= '0;
      tmr_q       <= '0;
      row_q       <= '0;
      pe_clear_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      done_q     <= (state_q == DONE);
      pe_clear_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_valid) begin
            feed_left_q <= cmd_k - K_WIDTH'(1);
            a_addr_q    <= cmd_a_base;
            b_addr_q    <= cmd_b_base;
            row_q       <= '0;
            pe_clear_q  <= (cmd_k != '0);
          end
        end
        FEED: begin
          feed_left_q <= feed_left_q - K_WIDTH'(1);
          a_addr_q    <= a_addr_q + ADDR_WIDTH'(1);
          b_addr_q    <= b_addr_q + ADDR_WIDTH'(1);
          tmr_q       <= FLUSH_LOAD;
        end
        FLUSH: tmr_q <= tmr_q - TMR_W'(1);
        DRAIN: if (out_ready) row_q <= row_q + SEL_W'(1);
        default: ;
      endcase
    end
  end

  // pe_en covers FEED minus its clear cycle plus the 2N-cycle FLUSH: k+2N-1 cycles in total.
  always_comb begin
    state_d     = state_q;
    start_ready = 1'b0;
    busy        = 1'b1;
    a_rd_en     = 1'b0;
    b_rd_en     = 1'b0;
    a_rd_addr   = '0;
    b_rd_addr   = '0;
    pe_en       = 1'b0;
    out_valid   = 1'b0;
    row_sel     = '0;
    out_data    = '0;
    case (state_q)
      IDLE: begin
        start_ready = 1'b1;
        busy        = 1'b0;
        if (start_valid) state_d = (cmd_k == '0) ? DONE : FEED;
      end
      FEED: begin
        a_rd_en   = 1'b1;
        b_rd_en   = 1'b1;
        a_rd_addr = a_addr_q;
        b_rd_addr = b_addr_q;
        pe_en     = !pe_clear_q;
        if (feed_left_q == '0) state_d = FLUSH;
      end
      FLUSH: begin
        pe_en = 1'b1;
        if (tmr_q == '0) state_d = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        row_sel   = row_q;
        out_data  = array_out;
        if (out_ready && row_q == LAST_ROW) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign pe_clear = pe_clear_q;
  assign done     = done_q;

  for (genvar r = 0; r < ARRAY_SIZE; r++) begin : g_lane
    sa_skew_line #(.D(r), .W(DATA_WIDTH)) u_skew_a (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (a_rd_en),
      .in_data  (a_rd_data[r*DATA_WIDTH +: DATA_WIDTH]),
      .out_data (row_in[r*DATA_WIDTH +: DATA_WIDTH])
    );
    sa_skew_line #(.D(r), .W(DATA_WIDTH)) u_skew_b (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (b_rd_en),
      .in_data  (b_rd_data[r*DATA_WIDTH +: DATA_WIDTH]),
      .out_data (col_in[r*DATA_WIDTH +: DATA_WIDTH])
    );
  end

`ifdef SA_SEQ_PERF_EN
  // The done cycle itself is counted, so the count stops one edge after done_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else if (state_q == IDLE && start_valid) begin
      perf_cycles <= 32'd1;
      perf_stall  <= '0;
    end else begin
      if ((state_q != IDLE || done_q) && perf_cycles != '1) perf_cycles <= perf_cycles + 32'd1;
      if (state_q == DRAIN && !out_ready && perf_stall != '1) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sa_tile_sequencer.sv
// tb_sa_tile_sequencer: random and directed tiles against a cycle-offset reference model,
// with behavioural SRAMs and a behavioural systolic array around the sequencer.
module tb_sa_tile_sequencer;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int KW = 8;
  localparam int AW = 10;
  localparam int LW = N * DW;
  localparam int OW = N * 3 * DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_valid, start_ready;
  logic [KW-1:0] cmd_k;
  logic [AW-1:0] cmd_a_base, cmd_b_base;
  logic          a_rd_en, b_rd_en;
  logic [AW-1:0] a_rd_addr, b_rd_addr;
  logic [LW-1:0] a_rd_data, b_rd_data;
  logic [LW-1:0] row_in, col_in;
  logic          pe_clear, pe_en;
  logic [1:0]    row_sel;
  logic [OW-1:0] array_out;
  logic          out_valid, out_ready;
  logic [OW-1:0] out_data;
  logic          busy, done;
`ifdef SA_SEQ_PERF_EN
  logic [31:0]   perf_cycles, perf_stall;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sa_tile_sequencer #(
    .ARRAY_SIZE(N), .DATA_WIDTH(DW), .K_WIDTH(KW), .ADDR_WIDTH(AW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .cmd_k       (cmd_k),
    .cmd_a_base  (cmd_a_base),
    .cmd_b_base  (cmd_b_base),
    .a_rd_en     (a_rd_en),
    .a_rd_addr   (a_rd_addr),
    .a_rd_data   (a_rd_data),
    .b_rd_en     (b_rd_en),
    .b_rd_addr   (b_rd_addr),
    .b_rd_data   (b_rd_data),
    .row_in      (row_in),
    .col_in      (col_in),
    .pe_clear    (pe_clear),
    .pe_en       (pe_en),
    .row_sel     (row_sel),
    .array_out   (array_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
`ifdef SA_SEQ_PERF_EN
    .perf_cycles (perf_cycles),
    .perf_stall  (perf_stall),
`endif
    .busy        (busy),
    .done        (done)
  );

  // Operand SRAMs, one-cycle read latency
  logic [LW-1:0] a_mem [1024];
  logic [LW-1:0] b_mem [1024];

  always @(posedge clk) begin
    if (a_rd_en) a_rd_data <= a_mem[a_rd_addr];
    if (b_rd_en) b_rd_data <= b_mem[b_rd_addr];
  end

  // Output-stationary array: A flows right, B flows down, each PE accumulates its own C(i,j)
  logic signed [DW-1:0]   ar  [N][N];
  logic signed [DW-1:0]   br  [N][N];
  logic signed [3*DW-1:0] acc [N][N];
  logic signed [DW-1:0]   a_in, b_in;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || pe_clear) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          ar[i][j]  <= '0;
          br[i][j]  <= '0;
          acc[i][j] <= '0;
        end
    end else if (pe_en) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          a_in = (j == 0) ? $signed(row_in[i*DW +: DW]) : ar[i][j-1];
          b_in = (i == 0) ? $signed(col_in[j*DW +: DW]) : br[i-1][j];
          ar[i][j]  <= a_in;
          br[i][j]  <= b_in;
          acc[i][j] <= acc[i][j] + a_in * b_in;
        end
    end
  end

  always_comb begin
    array_out = '0;
    for (int j = 0; j < N; j++) array_out[j*3*DW +: 3*DW] = acc[row_sel][j];
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_ctrl"}, 128'({start_ready, busy, done, a_rd_en, b_rd_en, pe_clear, pe_en,
                                   out_valid, row_sel}), 128'(10'b10_0000_0000));
    check_eq({tag, "_addr"}, 128'({a_rd_addr, b_rd_addr}), 128'(0));
    check_eq({tag, "_ops"},  128'({row_in, col_in}), 128'(0));
    check_eq({tag, "_out"},  128'(out_data), 128'(0));
  endtask

  // One tile: the reference is cycle offsets from the accept cycle and a plain dot-product result.
  task automatic run_tile(input int k, input logic [AW-1:0] ab, input logic [AW-1:0] bb,
                          input int stall_row, input int stall_len, input bit poke,
                          input bit rnd_ready);
    logic [OW-1:0] crow [N];
    logic [LW-1:0] wa, wb, e_ri, e_ci;
    logic [9:0]    e_ctrl, o_ctrl;
    logic [AW-1:0] e_aa, e_ba;
    logic [OW-1:0] e_od;
    int  row, h, end_c, stalls, stall_left, idx, sum;
    bit  e_busy, e_done, e_rd, e_clr, e_pe, e_ov, fin;

    for (int r = 0; r < N; r++) begin
      crow[r] = '0;
      for (int j = 0; j < N; j++) begin
        sum = 0;
        for (int v = 0; v < k; v++) begin
          wa = a_mem[ab + AW'(v)];
          wb = b_mem[bb + AW'(v)];
          sum += $signed(wa[r*DW +: DW]) * $signed(wb[j*DW +: DW]);
        end
        crow[r][j*3*DW +: 3*DW] = (3*DW)'(sum);
      end
    end

    @(negedge clk);
    check_eq("accept_ready", 128'(start_ready), 128'(1));
    start_valid = 1'b1;
    cmd_k       = KW'(k);
    cmd_a_base  = ab;
    cmd_b_base  = bb;
    row = 0; h = -1; stalls = 0; stall_left = stall_len; fin = 1'b0;

    for (int c = 1; c < k + 2*N + 300; c++) begin
      @(negedge clk);
      end_c  = (k == 0) ? 2 : ((h >= 0) ? h + 2 : -1);
      e_busy = (k == 0) ? (c == 1) : (h < 0 || c <= h + 1);
      e_done = (c == end_c);
      e_rd   = (k > 0) && (c <= k);
      e_clr  = (k > 0) && (c == 1);
      e_pe   = (k > 0) && (c >= 2) && (c <= k + 2*N);
      e_ov   = (k > 0) && (c >= k + 2*N + 1) && (h < 0);
      e_aa   = e_rd ? ab + AW'(c - 1) : '0;
      e_ba   = e_rd ? bb + AW'(c - 1) : '0;
      e_od   = e_ov ? crow[row] : '0;
      e_ri   = '0;
      e_ci   = '0;
      for (int r = 0; r < N; r++) begin
        idx = c - 2 - r;
        if (idx >= 0 && idx < k) begin
          wa = a_mem[ab + AW'(idx)];
          wb = b_mem[bb + AW'(idx)];
          e_ri[r*DW +: DW] = wa[r*DW +: DW];
          e_ci[r*DW +: DW] = wb[r*DW +: DW];
        end
      end
      e_ctrl = {!e_busy, e_busy, e_done, e_rd, e_rd, e_clr, e_pe, e_ov, 2'(e_ov ? row : 0)};
      o_ctrl = {start_ready, busy, done, a_rd_en, b_rd_en, pe_clear, pe_en, out_valid, row_sel};
      check_eq("ctrl",     128'(o_ctrl), 128'(e_ctrl));
      check_eq("a_addr",   128'(a_rd_addr), 128'(e_aa));
      check_eq("b_addr",   128'(b_rd_addr), 128'(e_ba));
      check_eq("row_in",   128'(row_in), 128'(e_ri));
      check_eq("col_in",   128'(col_in), 128'(e_ci));
      check_eq("out_data", 128'(out_data), 128'(e_od));
      if (end_c > 0 && c == end_c + 1) begin
        fin = 1'b1;
        break;
      end

      start_valid = poke && (c == 2);
      if (c == 1 || c == 2) begin
        cmd_k      = KW'($urandom);
        cmd_a_base = AW'($urandom);
        cmd_b_base = AW'($urandom);
      end
      out_ready = 1'b0;
      if (e_ov) begin
        if (row == stall_row && stall_left > 0) stall_left--;
        else out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (!out_ready) stalls++;
        else begin
          row++;
          if (row == N) h = c;
        end
      end
    end
    out_ready   = 1'b0;
    start_valid = 1'b0;
    check_eq("tile_done", 128'(fin), 128'(1));
`ifdef SA_SEQ_PERF_EN
    if (fin) begin
      check_eq("perf_cycles", 128'(perf_cycles), 128'(end_c + 1));
      check_eq("perf_stall",  128'(perf_stall),  128'(stalls));
    end
`endif
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got no summary, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    start_valid = 1'b0;
    cmd_k       = '0;
    cmd_a_base  = '0;
    cmd_b_base  = '0;
    out_ready   = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      a_mem[i] = LW'($urandom);
      b_mem[i] = LW'($urandom);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check_idle("idle");
    end
`ifdef SA_SEQ_PERF_EN
    check_eq("perf_rst", 128'({perf_cycles, perf_stall}), 128'(0));
`endif

    // A = identity, B = 1..16: drained rows must reproduce B
    for (int v = 0; v < N; v++) begin
      a_mem[10'h010 + v] = LW'(1) << (DW * v);
      for (int j = 0; j < N; j++) b_mem[10'h020 + v][j*DW +: DW] = DW'(v * N + j + 1);
    end
    run_tile(4, 10'h010, 10'h020, -1, 0, 1'b0, 1'b0);
    run_tile(0, 10'h055, 10'h066, -1, 0, 1'b0, 1'b0);
    run_tile(4, 10'h3FE, 10'h3FD, -1, 0, 1'b1, 1'b0);
    run_tile(4, 10'h100, 10'h200, 2, 10, 1'b0, 1'b0);

    // reset during FLUSH abandons the tile without a done pulse
    @(negedge clk);
    start_valid = 1'b1;
    cmd_k       = 8'd3;
    cmd_a_base  = AW'($urandom);
    cmd_b_base  = AW'($urandom);
    @(negedge clk);
    start_valid = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("flush_pe_en", 128'(pe_en), 128'(1));
    rst_n = 1'b0;
    #1;
    check_idle("rst_async");
`ifdef SA_SEQ_PERF_EN
    check_eq("perf_rst2", 128'({perf_cycles, perf_stall}), 128'(0));
`endif
    repeat (2) begin
      @(negedge clk);
      check_idle("rst_hold");
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_idle("rst_after");
    end
    run_tile(2, AW'($urandom), AW'($urandom), -1, 0, 1'b0, 1'b0);

    repeat (8) run_tile($urandom_range(1, 24), AW'($urandom), AW'($urandom),
                        $urandom_range(0, N - 1), $urandom_range(0, 3),
                        1'($urandom_range(0, 1)), 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
